// File: rtl/tinyalu_wide_if.sv
// Operand/handshake bundle for tinyalu_wide.
// The master drives operands and start; the slave returns status and result.
interface tinyalu_wide_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic [2:0]         op;
   logic               start;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic               err;

   modport master (output A, B, op, start, input busy, done, result, err);
   modport slave  (input A, B, op, start, output busy, done, result, err);
endinterface

// File: rtl/tinyalu_wide.sv
// Small multi-cycle ALU: single-cycle logic/add/sub and an iterative
// shift-add multiplier, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start with a non-NOP opcode
// CALC  | one-cycle add/sub/logic/illegal evaluation
// MULT  | shift-add multiply, one multiplier bit per cycle
// DONE  | one-cycle completion, done pulse high
module tinyalu_wide #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    tinyalu_wide_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, MULT, DONE} state_t;

    state_t            state;
    logic [RW-1:0]     a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [2:0]        op_reg;
    logic [RW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [RW-1:0]     result_r;

    logic [RW-1:0]     b_ext;
    logic [RW-1:0]     calc_res;
    logic              calc_err;
    logic [RW-1:0]     mul_step;

    assign b_ext    = {{WIDTH{1'b0}}, b_reg};
    assign mul_step = acc + (b_reg[0] ? a_reg : '0);

    // a_reg upper half is zero outside MULT, so 2*WIDTH arithmetic gives
    // the carry in bit WIDTH for ADD and the wrap to all ones for SUB.
    always_comb begin
        calc_res = '0;
        calc_err = 1'b0;
        case (op_reg)
            OP_ADD:  calc_res = a_reg + b_ext;
            OP_SUB:  calc_res = a_reg - b_ext;
            OP_AND:  calc_res = a_reg & b_ext;
            OP_OR:   calc_res = a_reg | b_ext;
            OP_XOR:  calc_res = a_reg ^ b_ext;
            OP_NOP, OP_MUL: calc_res = '0;
            default: calc_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.op != OP_NOP) begin
                        a_reg  <= {{WIDTH{1'b0}}, bus.A};
                        b_reg  <= bus.B;
                        op_reg <= bus.op;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH - 1);
                        busy_r <= 1'b1;
                        state  <= (bus.op == OP_MUL) ? MULT : CALC;
                    end
                end
                CALC: begin
                    result_r <= calc_res;
                    err_r    <= calc_err;
                    done_r   <= 1'b1;
                    state    <= DONE;
                end
                MULT: begin
                    acc   <= mul_step;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        result_r <= mul_step;
                        err_r    <= 1'b0;
                        done_r   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.err    = err_r;
    assign bus.result = result_r;
endmodule

// File: tb/tb_tinyalu_wide.sv
// Directed bench for tinyalu_wide at WIDTH=8 with hand-computed results.
module tb_tinyalu_wide;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    tinyalu_wide_if #(.WIDTH(W)) bus ();

    tinyalu_wide #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a request and returns just after the capturing edge k.
    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        bus.A = a; bus.B = b; bus.op = o; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Counts edges until done is seen; -1 if it never arrives.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1; bus.op = 3'b001; bus.A = 8'h11; bus.B = 8'h22;
        step(); step();
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        n_total++;
        if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
        n_total++;
        if (bus.err !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err); else n_pass++;
        n_total++;
        if (bus.result !== 16'h0000) $display("FAIL reset_result got=%h exp=0000", bus.result); else n_pass++;
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_add();
        do_start(8'hFF, 8'h01, 3'b001);
        n_total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL add_capture got busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done);
        else n_pass++;
        step();
        n_total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL add_done got done=%b busy=%b exp done=1 busy=1", bus.done, bus.busy);
        else n_pass++;
        n_total++;
        if (bus.result !== 16'h0100 || bus.err !== 1'b0)
            $display("FAIL add_result got=%h err=%b exp=0100 err=0", bus.result, bus.err);
        else n_pass++;
        step();
        n_total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL add_end got busy=%b done=%b exp 0 0", bus.busy, bus.done);
        else n_pass++;
    endtask

    task automatic test_logic();
        logic [7:0]  ta [5];
        logic [7:0]  tb [5];
        logic [2:0]  to [5];
        logic [15:0] te [5];
        int n;
        ta = '{8'hC3, 8'hC3, 8'hC3, 8'h05, 8'h00};
        tb = '{8'h5A, 8'h5A, 8'h5A, 8'h03, 8'h01};
        to = '{3'b010, 3'b110, 3'b011, 3'b101, 3'b101};
        te = '{16'h0042, 16'h00DB, 16'h0099, 16'h0002, 16'hFFFF};
        for (int i = 0; i < 5; i++) begin
            do_start(ta[i], tb[i], to[i]);
            wait_done(n);
            n_total++;
            if (n !== 1 || bus.result !== te[i] || bus.err !== 1'b0)
                $display("FAIL logic_op%0d got lat=%0d res=%h err=%b exp lat=1 res=%h err=0",
                         to[i], n, bus.result, bus.err, te[i]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_illegal();
        int n;
        do_start(8'hAA, 8'h55, 3'b111);
        wait_done(n);
        n_total++;
        if (n !== 1 || bus.err !== 1'b1 || bus.result !== 16'h0000)
            $display("FAIL illegal got lat=%0d err=%b res=%h exp lat=1 err=1 res=0000", n, bus.err, bus.result);
        else n_pass++;
        step();
        n_total++;
        if (bus.err !== 1'b1) $display("FAIL illegal_hold got err=%b exp=1", bus.err); else n_pass++;
        do_start(8'hF0, 8'h3C, 3'b011);
        wait_done(n);
        n_total++;
        if (bus.err !== 1'b0 || bus.result !== 16'h00CC)
            $display("FAIL after_illegal got err=%b res=%h exp err=0 res=00CC", bus.err, bus.result);
        else n_pass++;
        step();
    endtask

    task automatic test_mul();
        int n;
        do_start(8'hFF, 8'hFF, 3'b100);
        wait_done(n);
        n_total++;
        if (n !== 8 || bus.result !== 16'hFE01 || bus.err !== 1'b0)
            $display("FAIL mul_ff got lat=%0d res=%h err=%b exp lat=8 res=FE01 err=0", n, bus.result, bus.err);
        else n_pass++;
        step();
        n_total++;
        if (bus.busy !== 1'b0 || bus.result !== 16'hFE01)
            $display("FAIL mul_end got busy=%b res=%h exp busy=0 res=FE01", bus.busy, bus.result);
        else n_pass++;
        do_start(8'h00, 8'hAB, 3'b100);
        wait_done(n);
        n_total++;
        if (n !== 8 || bus.result !== 16'h0000)
            $display("FAIL mul_zero got lat=%0d res=%h exp lat=8 res=0000", n, bus.result);
        else n_pass++;
        step();
        do_start(8'h0D, 8'hB7, 3'b100);
        wait_done(n);
        n_total++;
        if (n !== 8 || bus.result !== 16'h094B)
            $display("FAIL mul_mixed got lat=%0d res=%h exp lat=8 res=094B", n, bus.result);
        else n_pass++;
        step();
    endtask

    task automatic test_mul_reset();
        int n;
        int seen_done;
        seen_done = 0;
        do_start(8'h0F, 8'h0F, 3'b100);
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.done === 1'b1) seen_done++;
        end
        reset = 1'b1;
        #1;
        n_total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.result !== 16'h0000)
            $display("FAIL mul_reset_outs got busy=%b done=%b err=%b res=%h exp all 0",
                     bus.busy, bus.done, bus.err, bus.result);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        n_total++;
        if (seen_done !== 0) $display("FAIL mul_reset_abort got activity=%0d exp=0", seen_done); else n_pass++;
        do_start(8'h12, 8'h34, 3'b001);
        wait_done(n);
        n_total++;
        if (n !== 1 || bus.result !== 16'h0046)
            $display("FAIL post_reset_add got lat=%0d res=%h exp lat=1 res=0046", n, bus.result);
        else n_pass++;
        step();
    endtask

    task automatic test_ignore_start();
        int n;
        bus.A = 8'h10; bus.B = 8'h10; bus.op = 3'b100; bus.start = 1'b1;
        step();
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            bus.A = 8'(i * 7 + 1); bus.B = 8'(i * 3 + 2); bus.op = 3'(i % 7);
            step();
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
        bus.start = 1'b0;
        n_total++;
        if (n !== 8 || bus.result !== 16'h0100)
            $display("FAIL mul_ignore_start got lat=%0d res=%h exp lat=8 res=0100", n, bus.result);
        else n_pass++;
        step();
        step();
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL no_extra_accept got busy=%b exp=0", bus.busy); else n_pass++;
    endtask

    task automatic test_nop();
        int act;
        act = 0;
        bus.A = 8'h77; bus.B = 8'h11; bus.op = 3'b000; bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.busy === 1'b1 || bus.done === 1'b1) act++;
        end
        bus.start = 1'b0;
        n_total++;
        if (act !== 0 || bus.result !== 16'h0100)
            $display("FAIL nop got activity=%0d res=%h exp activity=0 res=0100", act, bus.result);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_start(8'h01, 8'h02, 3'b001);
        step();
        n_total++;
        if (bus.done !== 1'b1 || bus.result !== 16'h0003)
            $display("FAIL b2b_first got done=%b res=%h exp done=1 res=0003", bus.done, bus.result);
        else n_pass++;
        step();
        bus.A = 8'h30; bus.B = 8'h04; bus.op = 3'b101; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_total++;
        if (bus.busy !== 1'b1 || bus.result !== 16'h0003)
            $display("FAIL b2b_accept got busy=%b res=%h exp busy=1 res=0003", bus.busy, bus.result);
        else n_pass++;
        step();
        n_total++;
        if (bus.done !== 1'b1 || bus.result !== 16'h002C)
            $display("FAIL b2b_second got done=%b res=%h exp done=1 res=002C", bus.done, bus.result);
        else n_pass++;
        step();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b0;
        bus.A = '0; bus.B = '0; bus.op = '0; bus.start = 1'b0;
        #2;
        test_reset();
        test_add();
        test_logic();
        test_illegal();
        test_mul();
        test_mul_reset();
        test_ignore_start();
        test_nop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tinyalu_wide.md
TINYALU_WIDE -- requirements
Module: tinyalu_wide

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: A  input  WIDTH  operand A, unsigned.
REQ-005 Port: B  input  WIDTH  operand B, unsigned.
REQ-006 Port: op  input  3  opcode: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB, 110 OR, 111 illegal.
REQ-007 Port: start  input  1  request, sampled only in IDLE.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle completion pulse; result and err are valid in that cycle.
REQ-010 Port: result  output  2*WIDTH  operation result, registered.
REQ-011 Port: err  output  1  illegal-opcode flag, valid with done.

Function
REQ-012 FSM states SHALL be IDLE, CALC, MULT and DONE, all registered.
REQ-013 In IDLE, with start=1 and op!=NOP at edge k: capture A, B and op, set busy=1, go to MULT if op=MUL, else CALC.
REQ-014 In IDLE, start=1 with op=NOP SHALL be ignored: no state change, no done, result unchanged.
REQ-015 CALC SHALL compute in one edge (k+1), load result, set done=1, and go to DONE.
REQ-016 ADD SHALL produce result = zero-extended A+B, carry in bit WIDTH, upper bits 0.
REQ-017 SUB SHALL produce result = (A-B) mod 2^(2*WIDTH), so 0-1 gives all ones.
REQ-018 AND, OR and XOR SHALL be bitwise on WIDTH bits, zero-extended to 2*WIDTH.
REQ-019 Illegal op (111) SHALL take the CALC path with result=0 and err=1; err is 0 for all legal ops.
REQ-020 MULT SHALL be an iterative shift-add: one multiplier bit per edge, WIDTH iterations at edges k+1..k+WIDTH, with a log2(WIDTH)+1-bit iteration counter.
REQ-021 The final MUL iteration (edge k+WIDTH) SHALL load result = full 2*WIDTH-bit unsigned product, set done=1, and go to DONE.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE with done=0 and busy=0.
REQ-023 busy SHALL be 1 from edge k to the edge leaving DONE; busy=0 in IDLE only.
REQ-024 start in any state other than IDLE SHALL be ignored, with no effect on captured operands or timing.
REQ-025 A, B and op changes after capture SHALL NOT affect the running operation.
REQ-026 result and err SHALL hold their values from the last done until the next done; they are not cleared on a new start.
REQ-027 Back-to-back: start asserted in the first IDLE cycle after DONE SHALL be accepted at that edge.
REQ-028 Latency: logic, add, sub and illegal ops SHALL raise done after 1 edge; MUL after WIDTH edges; start-to-start throughput is 3 cycles, or WIDTH+2 for MUL.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, busy=0, done=0, err=0, result=0, and clear the counter and captured operands.
REQ-030 Reset asserted mid-operation (CALC or MULT) SHALL abort it with no done pulse; the first start after reset release SHALL complete normally.
REQ-031 start SHALL be ignored while reset=1.

Verification (WIDTH=8)
REQ-032 ADD A=0xFF, B=0x01 -> done 1 edge after capture, result=0x0100, err=0, busy high for 2 cycles.
REQ-033 MUL A=0xFF, B=0xFF -> done exactly 8 edges after capture, result=0xFE01; MUL A=0x00, B=0xAB -> result=0x0000.
REQ-034 SUB A=0x00, B=0x01 -> result=0xFFFF; op=111 -> done with err=1, result=0x0000; the next legal op -> err=0.
REQ-035 MUL started, reset pulsed at edge k+4 -> no done, all outputs 0; then ADD 0x12+0x34 -> result=0x0046.
REQ-036 start pulsed every cycle with changing A, B during MUL 0x10*0x10 -> only the first is accepted, result=0x0100; NOP start -> busy stays 0, no done.
